// File: rtl/flag_int_ctrl_if.sv
// Flag/interrupt sequencer bus: control-unit strobes in, architectural flags and ISR status out.
// Registered outputs, one-cycle latency; no backpressure (strobes always accepted).
interface flag_int_if;
   logic fetch_bnd;
   logic alu_c;
   logic alu_z;
   logic c_ld;
   logic z_ld;
   logic c_set;
   logic c_clr;
   logic sei;
   logic cli;
   logic reti;
   logic irq;
   logic c_flag;
   logic z_flag;
   logic i_en;
   logic shad_c;
   logic shad_z;
   logic int_taken;
   logic in_isr;

   modport master (
      output fetch_bnd, alu_c, alu_z, c_ld, z_ld, c_set, c_clr, sei, cli, reti, irq,
      input  c_flag, z_flag, i_en, shad_c, shad_z, int_taken, in_isr
   );

   modport slave (
      input  fetch_bnd, alu_c, alu_z, c_ld, z_ld, c_set, c_clr, sei, cli, reti, irq,
      output c_flag, z_flag, i_en, shad_c, shad_z, int_taken, in_isr
   );
endinterface

// File: rtl/flag_int_ctrl.sv
// C/Z/interrupt-enable write arbitration plus single-level interrupt entry/return FSM.
// All outputs registered, one-cycle latency from strobe; no backpressure.
module flag_int_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   flag_int_if.slave   bus
);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      PEND  = 2'd1,
      ENTER = 2'd2,
      ISR   = 2'd3
   } state_t;

   state_t state;
   logic   c_q, z_q, ie_q, shad_c_q, shad_z_q, int_taken_q, in_isr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= RUN;
         c_q         <= 1'b0;
         z_q         <= 1'b0;
         ie_q        <= 1'b0;
         shad_c_q    <= 1'b0;
         shad_z_q    <= 1'b0;
         int_taken_q <= 1'b0;
         in_isr_q    <= 1'b0;
      end else begin
         int_taken_q <= 1'b0;
         in_isr_q    <= 1'b0;
         case (state)
            ENTER: begin
               // Entry cycle owns the flags: snapshot, mask, ignore every strobe.
               shad_c_q <= c_q;
               shad_z_q <= z_q;
               ie_q     <= 1'b0;
               state    <= ISR;
               in_isr_q <= 1'b1;
            end
            ISR: begin
               if (bus.reti) begin
                  c_q   <= shad_c_q;
                  z_q   <= shad_z_q;
                  ie_q  <= 1'b1;
                  state <= RUN;
               end else begin
                  if (bus.c_clr)      c_q <= 1'b0;
                  else if (bus.c_set) c_q <= 1'b1;
                  else if (bus.c_ld)  c_q <= bus.alu_c;
                  if (bus.z_ld)       z_q <= bus.alu_z;
                  in_isr_q <= 1'b1;
               end
            end
            default: begin
               if (bus.c_clr)      c_q <= 1'b0;
               else if (bus.c_set) c_q <= 1'b1;
               else if (bus.c_ld)  c_q <= bus.alu_c;
               if (bus.z_ld)       z_q <= bus.alu_z;
               if (bus.cli)        ie_q <= 1'b0;
               else if (bus.sei)   ie_q <= 1'b1;

               if (state == RUN) begin
                  if (bus.irq && ie_q) state <= PEND;
               end else if (bus.cli) begin
                  state <= RUN;
               end else if (bus.fetch_bnd) begin
                  state       <= ENTER;
                  int_taken_q <= 1'b1;
               end
            end
         endcase
      end
   end

   assign bus.c_flag    = c_q;
   assign bus.z_flag    = z_q;
   assign bus.i_en      = ie_q;
   assign bus.shad_c    = shad_c_q;
   assign bus.shad_z    = shad_z_q;
   assign bus.int_taken = int_taken_q;
   assign bus.in_isr    = in_isr_q;

endmodule

// File: tb/tb_flag_int_ctrl.sv
// Bench for flag_int_ctrl: directed scenarios then random strobes against a behavioural model.
module tb_flag_int_ctrl;

   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_err;

   flag_int_if bus ();

   flag_int_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: mode is 0 running, 1 interrupt waiting for a boundary, 2 vectoring, 3 servicing.
   int m_mode;
   bit m_c, m_z, m_ie, m_sc, m_sz;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = 0;
      m_c = 0; m_z = 0; m_ie = 0; m_sc = 0; m_sz = 0;
   endtask

   task automatic model_step();
      int nm;
      bit nc, nz, nie;
      nm = m_mode; nc = m_c; nz = m_z; nie = m_ie;
      if (m_mode == 2) begin
         m_sc = m_c;
         m_sz = m_z;
         nie  = 0;
         nm   = 3;
      end else if (m_mode == 3 && bus.reti) begin
         nc = m_sc; nz = m_sz; nie = 1; nm = 0;
      end else begin
         nc = bus.c_clr ? 1'b0 : bus.c_set ? 1'b1 : bus.c_ld ? bus.alu_c : m_c;
         nz = bus.z_ld ? bus.alu_z : m_z;
         if (m_mode != 3) nie = bus.cli ? 1'b0 : bus.sei ? 1'b1 : m_ie;
         if (m_mode == 0 && bus.irq && m_ie) nm = 1;
         if (m_mode == 1) nm = bus.cli ? 0 : (bus.fetch_bnd ? 2 : 1);
      end
      m_mode = nm; m_c = nc; m_z = nz; m_ie = nie;
   endtask

   function automatic logic [7:0] dut_outs();
      return {1'b0, bus.c_flag, bus.z_flag, bus.i_en, bus.shad_c, bus.shad_z,
              bus.int_taken, bus.in_isr};
   endfunction

   function automatic logic [7:0] model_outs();
      return {1'b0, m_c, m_z, m_ie, m_sc, m_sz, 1'(m_mode == 2), 1'(m_mode == 3)};
   endfunction

   task automatic clr_in();
      bus.fetch_bnd = 0; bus.alu_c = 0; bus.alu_z = 0; bus.c_ld = 0; bus.z_ld = 0;
      bus.c_set = 0; bus.c_clr = 0; bus.sei = 0; bus.cli = 0; bus.reti = 0; bus.irq = 0;
   endtask

   task automatic rand_in(input int p);
      bus.fetch_bnd = ($urandom_range(0, 99) < 30);
      bus.alu_c = 1'($urandom);
      bus.alu_z = 1'($urandom);
      bus.c_ld  = ($urandom_range(0, 99) < p);
      bus.z_ld  = ($urandom_range(0, 99) < p);
      bus.c_set = ($urandom_range(0, 99) < p);
      bus.c_clr = ($urandom_range(0, 99) < p);
      bus.sei   = ($urandom_range(0, 99) < 25);
      bus.cli   = ($urandom_range(0, 99) < 8);
      bus.reti  = ($urandom_range(0, 99) < 15);
      bus.irq   = ($urandom_range(0, 99) < 30);
   endtask

   // One clock: model advances on the edge, outputs compared 1 ns later; inputs then cleared.
   task automatic cyc(input string tag);
      @(posedge clk);
      model_step();
      #1;
      chk(tag, dut_outs(), model_outs());
      clr_in();
   endtask

   task automatic pulse_reset();
      #2 rst_n = 0;
      model_reset();
      #1 chk("rst_async", dut_outs(), model_outs());
      #1 rst_n = 1;
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      clr_in();
      model_reset();
      rst_n = 0;

      // Reset held with inputs toggling
      for (int i = 0; i < 5; i++) begin
         rand_in(50);
         @(posedge clk);
         #1;
         chk("rst_hold", dut_outs(), 8'h00);
      end
      clr_in();
      rst_n = 1;
      cyc("rst_release");
      chk("rst_state", dut_outs(), 8'h00);

      // Carry priority
      bus.c_clr = 1; bus.c_set = 1; bus.c_ld = 1; bus.alu_c = 1;
      cyc("cpri_clr");
      chk("cpri_clr_c", 8'(bus.c_flag), 8'h00);
      bus.c_set = 1; bus.c_ld = 1; bus.alu_c = 0;
      cyc("cpri_set");
      chk("cpri_set_c", 8'(bus.c_flag), 8'h01);
      bus.c_ld = 1; bus.alu_c = 0;
      cyc("cpri_ld");
      chk("cpri_ld_c", 8'(bus.c_flag), 8'h00);

      // Interrupt round trip
      bus.sei = 1;                           cyc("rt_sei");
      bus.c_set = 1; bus.z_ld = 1;           cyc("rt_flags");
      bus.irq = 1;                           cyc("rt_irq");
      cyc("rt_wait1");
      cyc("rt_wait2");
      bus.fetch_bnd = 1;                     cyc("rt_enter");
      chk("rt_int_taken", 8'(bus.int_taken), 8'h01);
      cyc("rt_isr");
      chk("rt_isr_state", {3'b0, bus.int_taken, bus.i_en, bus.shad_c, bus.shad_z, bus.in_isr},
          8'b0000_0101);
      bus.c_clr = 1; bus.z_ld = 1; bus.alu_z = 1;
      cyc("rt_isr_upd");
      chk("rt_isr_cz", {6'b0, bus.c_flag, bus.z_flag}, 8'h01);
      bus.reti = 1;                          cyc("rt_reti");
      chk("rt_restore", {4'b0, bus.c_flag, bus.z_flag, bus.i_en, bus.in_isr}, 8'b0000_1010);

      // Masked irq, then cancel from pending
      bus.cli = 1;                           cyc("mask_cli");
      for (int i = 0; i < 3; i++) begin
         bus.irq = 1;                        cyc("mask_irq");
         chk("mask_no_take", {6'b0, bus.int_taken, bus.in_isr}, 8'h00);
      end
      bus.sei = 1;                           cyc("cancel_sei");
      bus.irq = 1;                           cyc("cancel_pend");
      bus.cli = 1; bus.fetch_bnd = 1;        cyc("cancel_cli");
      for (int i = 0; i < 3; i++) begin
         bus.fetch_bnd = 1;                  cyc("cancel_after");
         chk("cancel_no_take", {6'b0, bus.int_taken, bus.i_en}, 8'h00);
      end

      // Stray reti in RUN with C=1, Z=1, shadow 0
      pulse_reset();
      bus.c_set = 1; bus.z_ld = 1; bus.alu_z = 1;  cyc("stray_setup");
      bus.reti = 1;                                cyc("stray_reti");
      chk("stray_flags", {5'b0, bus.c_flag, bus.z_flag, bus.i_en}, 8'b0000_0110);

      // reti and c_set together in ISR: restored C=0 wins
      bus.sei = 1; bus.c_clr = 1;            cyc("rc_setup");
      bus.irq = 1;                           cyc("rc_irq");
      bus.fetch_bnd = 1;                     cyc("rc_enter");
      cyc("rc_isr");
      bus.reti = 1; bus.c_set = 1;           cyc("rc_reti");
      chk("rc_restore_c", 8'(bus.c_flag), 8'h00);

      // Async reset while servicing, later reti ignored
      bus.c_set = 1;                         cyc("ar_setup");
      bus.irq = 1;                           cyc("ar_irq");
      bus.fetch_bnd = 1;                     cyc("ar_enter");
      cyc("ar_isr");
      chk("ar_in_isr", 8'(bus.in_isr), 8'h01);
      pulse_reset();
      chk("ar_cleared", dut_outs(), 8'h00);
      bus.reti = 1;                          cyc("ar_reti");
      chk("ar_reti_none", dut_outs(), 8'h00);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         rand_in((i % 500 < 250) ? 10 : 40);
         cyc("rand");
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/flag_int_ctrl.md
# flag_int_ctrl

Sequencer for the MCU's C and Z flag registers and the interrupt-enable flag. It arbitrates every write source to C and Z: ALU loads, SEC/CLC, and the interrupt save/restore path. It also runs the single-level interrupt entry/return state machine that shadows the flags on ISR entry and restores them on RETI. It sits between the control unit (which drives the strobes) and the branch logic and ALU (which consume `c_flag`/`z_flag`).

## Interface
- Parameters: none.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `fetch_bnd`  in  1  one-cycle strobe from the control unit at each instruction boundary (fetch state).
- `alu_c`, `alu_z`  in  1 each  ALU carry/zero results.
- `c_ld`, `z_ld`  in  1 each  load C/Z from `alu_c`/`alu_z`.
- `c_set`, `c_clr`  in  1 each  SEC / CLC strobes.
- `sei`, `cli`  in  1 each  set/clear interrupt enable.
- `reti`  in  1  RETI executing (one-cycle strobe).
- `irq`  in  1  external interrupt request, level.
- `c_flag`, `z_flag`  out  1 each  architectural flags.
- `i_en`  out  1  interrupt-enable flag.
- `shad_c`, `shad_z`  out  1 each  shadow flags, exposed for debug.
- `int_taken`  out  1  one-cycle pulse telling the control unit to vector to the ISR.
- `in_isr`  out  1  high while in ISR state.

## Operation
- FSM states: RUN, PEND, ENTER, ISR.
- RUN:
  - `irq & i_en` -> PEND.
  - `irq` with `i_en=0` is ignored and not latched.
- PEND:
  - `cli` -> RUN. Cancel; `cli` wins over a same-cycle `fetch_bnd`.
  - else `fetch_bnd` -> ENTER.
  - Otherwise stay in PEND; `irq` deassertion does not cancel.
- ENTER (exactly one cycle):
  - `int_taken=1`.
  - `shad_c<=c_flag`, `shad_z<=z_flag`, using the register values at the start of the cycle.
  - `i_en<=0`.
  - All flag strobes (`c_ld`, `z_ld`, `c_set`, `c_clr`, `sei`, `cli`, `reti`) are ignored.
  - -> ISR.
- ISR:
  - `in_isr=1`.
  - `sei`/`cli` ignored; `irq` ignored.
  - `reti` -> RUN with `c_flag<=shad_c`, `z_flag<=shad_z`, `i_en<=1`.
- C update priority, highest first: `reti` restore (ISR only) > `c_clr` > `c_set` > `c_ld` > hold.
- Z update priority: `reti` restore (ISR only) > `z_ld` > hold. Z has no set/clr.
- `i_en` update priority outside ISR/ENTER: `cli` > `sei` > hold.
- `reti` in RUN or PEND: no flag restore, no `i_en` change, no state change.
- In ISR, `c_ld`, `z_ld`, `c_set`, `c_clr` update the flags normally unless `reti` is asserted in the same cycle; restore wins.
- Shadow registers change only in ENTER.

## Timing
- All state and outputs are registered. `int_taken` and `in_isr` decode from state (Moore).
- Reset (async assert, sync to `clk` on release):
  - state=RUN.
  - `c_flag=0`, `z_flag=0`, `i_en=0`, `shad_c=0`, `shad_z=0`.
  - `int_taken=0`, `in_isr=0`.
- Flag and `i_en` writes are visible the cycle after the strobe edge, with one-cycle latency.
- `irq` sampled at edge N in RUN -> PEND at N+1. There is no shortcut even if `fetch_bnd` is high at N.
- `fetch_bnd` at edge M in PEND -> ENTER during M..M+1 (`int_taken` high), ISR from M+2.
- `reti` at edge R in ISR -> RUN and restored flags visible from R+1.
- `rst_n` low mid-ENTER or mid-ISR: immediate return to RUN with reset values. There is no pending or restore carry-over.

## Test plan
- Reset: hold `rst_n=0` with all inputs toggling -> all outputs 0. Release -> RUN, flags 0.
- C priority: `c_clr=c_set=c_ld=1`, `alu_c=1` -> `c_flag=0`. Then `c_set=c_ld=1`, `alu_c=0` -> `c_flag=1`. Then `c_ld=1`, `alu_c=0` -> `c_flag=0`.
- Interrupt round trip:
  - `sei`; set C=1, Z=0; pulse `irq`.
  - 3 cycles later pulse `fetch_bnd` -> `int_taken` for exactly 1 cycle, `i_en=0`, `shad_c=1`, `shad_z=0`.
  - In ISR, `c_clr` and `z_ld` with `alu_z=1` -> C=0, Z=1.
  - `reti` -> next cycle C=1, Z=0, `i_en=1`, `in_isr=0`.
- Masking and cancel:
  - `irq` with `i_en=0` -> stays RUN, no `int_taken`.
  - With `i_en=1`, `irq` -> PEND, then `cli` and `fetch_bnd` in the same cycle -> RUN, `int_taken` never asserts, `i_en=0`.
- Stray `reti` in RUN with C=1, Z=1, shadow 0 -> flags unchanged, `i_en` unchanged. Same-cycle `reti` and `c_set` in ISR -> restored value wins.
- Async reset mid-ISR: assert `rst_n=0` between clock edges -> outputs clear immediately, and a subsequent `reti` has no effect.
